fetch: RTL
==========

# fetch

Instruction fetch stage (IF) of the RV32I 5-stage pipeline. Owns the program counter and drives a variable-latency instruction-memory request/acknowledge interface. Writes the IF/ID pipeline register (`pc_out`, `instr_out`, `valid_out`) that the decode stage consumes. Applies hazard-unit stalls, EX-stage branch redirects and flushes, and uses a one-entry buffer so that no fetched word is lost while stalled.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `stall_in`  in  1  hazard unit: hold the IF/ID register contents.
- `redirect_in`  in  1  EX stage: branch/jump taken, so flush IF/ID and refetch.
- `redirect_pc_in`  in  32  redirect target address.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address (word-aligned).
- `imem_ack`  in  1  request complete; `imem_rdata` is valid in this cycle.
- `imem_rdata`  in  32  instruction word.
- `pc_out`  out  32  IF/ID: PC of `instr_out`.
- `instr_out`  out  32  IF/ID: instruction word.
- `valid_out`  out  1  IF/ID: entry holds a real instruction.
- `misalign_out`  out  1  misaligned redirect detected (sticky).

## Operation
- Memory protocol:
  - `imem_addr` must stay stable while `imem_req`=1, until the cycle with `imem_ack`=1.
  - `imem_ack` in the same cycle as `imem_req` is legal (zero-wait memory).
  - `imem_ack` is ignored when `imem_req`=0.
- Registers: `pc` (next address to fetch), `target`, one buffer entry {pc, instr}, FSM state.
- `FETCH`: `imem_req`=1, `imem_addr`=`pc`.
  - ack, no redirect, `stall_in`=0: IF/ID <= {`pc`, `imem_rdata`, valid=1}; `pc` += 4; stay in FETCH.
  - ack, no redirect, `stall_in`=1: buffer <= {`pc`, `imem_rdata`}; `pc` += 4; go to `BUF_FULL`.
  - ack with redirect: discard `imem_rdata`; `pc` <= `redirect_pc_in`; stay in FETCH.
  - no ack, with redirect: `target` <= `redirect_pc_in`; go to `DRAIN`.
  - no ack, no redirect: no state change.
- `DRAIN`: `imem_req`=1, `imem_addr` is the old `pc`, unchanged.
  - A further redirect overwrites `target` (the latest redirect wins).
  - On ack: discard the data; `pc` <= `target`, or `redirect_pc_in` if a redirect arrives in the same cycle; go to FETCH.
- `BUF_FULL`: `imem_req`=0.
  - Redirect: drop the buffer; `pc` <= `redirect_pc_in`; go to FETCH.
  - Otherwise, when `stall_in`=0: IF/ID <= buffer with valid=1; go to FETCH.
- IF/ID update priority: `rst` > `redirect_in` > `stall_in` > load.
  - Redirect flushes IF/ID (valid=0, instr=NOP) even when stalled.
  - `stall_in`=1 with no redirect: IF/ID holds.
  - No stall and nothing to load: bubble (valid=0, instr=NOP, `pc_out` holds).
- NOP = 32'h0000_0013 (addi x0,x0,0).
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.

## Timing
- Reset values:
  - `pc`=`RESET_PC`; state=FETCH.
  - `pc_out`=32'h0, `instr_out`=NOP, `valid_out`=0, `misalign_out`=0.
  - Buffer and `target` are cleared.
  - `imem_req`=1 and `imem_addr`=`RESET_PC` from the first cycle after reset; acks while `rst`=1 are ignored.
- `imem_req` and `imem_addr` are combinational from state and `pc`. IF/ID outputs are registered.
- Latency: ack in cycle t gives the instruction on IF/ID at t+1.
  - With zero-wait memory, throughput is 1 instruction/cycle.
- Redirect at t (FETCH or BUF_FULL): `valid_out`=0 at t+1; the target request is issued at t+1; the target is valid at t+2 at the earliest.
- Redirect during an outstanding request: the target request is issued the cycle after the old request's ack.
- Reset mid-transaction: all state resets immediately. The memory must tolerate an abandoned request.

## Configuration
- `FETCH_MISALIGN_EN` defined:
  - A redirect with `redirect_pc_in[1:0]`≠0 sets `misalign_out`=1 at t+1 and moves the FSM to `HALT`.
  - In `HALT`: `imem_req`=0 and IF/ID is bubbles, until reset.
  - If a request is outstanding, it first completes through DRAIN, then the FSM enters HALT.
- `FETCH_MISALIGN_EN` undefined: `misalign_out` is tied to 0 and `redirect_pc_in[1:0]` is forced to 2'b00.

## Structure
- Shared package `rv32i_pkg` holds:
  - `NOP_INSTR`;
  - the fetch FSM state encoding (FETCH, DRAIN, BUF_FULL, HALT);
  - `PC_STEP`=4.
- One sub-module, `fetch_buf`: the one-entry {pc, instr} holding register with load, drop and full flag.

## Test plan
- Reset, `RESET_PC`=32'h100, zero-wait memory, no stall: fetches from 100, 104, 108 on consecutive cycles; `pc_out` = 100 one cycle after the first ack.
- Stall held 3 cycles while a fetch is acked: the acked word goes to the buffer, `imem_req`=0 and IF/ID holds. After release, the buffered word appears, then fetch resumes at the next address. No word is lost or duplicated.
- 3-cycle-latency memory, redirect to 32'h200 one cycle after the request to 32'h104: `imem_addr` stays 104 until the ack, that data is discarded, and the next request is to 200.
- Two redirects (32'h300, then 32'h400) during DRAIN: the only fetch after the ack is to 400; `valid_out`=0 throughout.
- Redirect coinciding with `stall_in`=1 and a full buffer: IF/ID is flushed (valid=0, NOP), the buffer is dropped and the next request is to the target.
- With `FETCH_MISALIGN_EN`, redirect to 32'h202: `misalign_out`=1 next cycle, `imem_req` stays 0 and the condition persists until `rst`. Without the macro, the redirect fetches 32'h200.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I pipeline constants and fetch FSM encoding
package rv32i_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP = 32'd4;
  typedef enum logic [1:0] {FETCH, DRAIN, BUF_FULL, HALT} fetch_state_t;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction-memory request/acknowledge bus
interface fetch_if;
  logic imem_req;
  logic [31:0] imem_addr;
  logic imem_ack;
  logic [31:0] imem_rdata;
  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_buf.sv
// fetch_buf: one-entry {pc, instr} holding register with load, drop and full flag
module fetch_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        drop,
  input  logic [31:0] pc_d,
  input  logic [31:0] instr_d,
  output logic [31:0] pc_q,
  output logic [31:0] instr_q,
  output logic        full
);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc_q <= '0;
      instr_q <= '0;
      full <= 1'b0;
    end else if (load) begin
      pc_q <= pc_d;
      instr_q <= instr_d;
      full <= 1'b1;
    end else if (drop) full <= 1'b0;
endmodule

// File: rtl/fetch.sv
// fetch: RV32I IF stage with variable-latency imem, stall buffer and redirects.
// Define FETCH_MISALIGN_EN to trap misaligned redirect targets into HALT.
module fetch
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in,
  fetch_if.master     imem,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        valid_out,
  output logic        misalign_out
);
  fetch_state_t state, state_nx;
  logic [31:0] pc, target, rpc, buf_pc, buf_instr;
  logic ack, mis, buf_full, buf_load, buf_drop, fetch_hit;
`ifdef FETCH_MISALIGN_EN
  logic mis_q;
  assign rpc = redirect_pc_in;
  assign mis = redirect_in && rpc[1:0] != 2'b00;
  always_ff @(posedge clk or posedge rst)
    if (rst) mis_q <= 1'b0;
    else mis_q <= mis_q | mis;
  assign misalign_out = mis_q;
`else
  assign rpc = redirect_pc_in & ~32'h3;
  assign mis = 1'b0;
  assign misalign_out = 1'b0;
`endif
  assign ack = imem.imem_ack & imem.imem_req;
  assign fetch_hit = state == FETCH && ack;
  assign buf_load = fetch_hit && !redirect_in && stall_in;
  assign buf_drop = buf_full && (redirect_in || !stall_in);
  fetch_buf u_buf (
    .clk(clk), .rst(rst), .load(buf_load), .drop(buf_drop),
    .pc_d(pc), .instr_d(imem.imem_rdata),
    .pc_q(buf_pc), .instr_q(buf_instr), .full(buf_full)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= FETCH;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      FETCH:    state_nx = ack ? (redirect_in ? (mis ? HALT : FETCH) : (stall_in ? BUF_FULL : FETCH))
                               : (redirect_in ? DRAIN : FETCH);
      DRAIN:    state_nx = ack ? ((misalign_out || mis) ? HALT : FETCH) : DRAIN;
      BUF_FULL: state_nx = redirect_in ? (mis ? HALT : FETCH) : (stall_in ? BUF_FULL : FETCH);
      default:  state_nx = HALT;
    endcase
  end
  always_comb begin
    imem.imem_req = state == FETCH || state == DRAIN;
    imem.imem_addr = pc;
  end
  // target always tracks the latest redirect; it is only consumed when a drain completes
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc <= RESET_PC;
      target <= '0;
    end else begin
      if (redirect_in) target <= rpc;
      if (fetch_hit) pc <= redirect_in ? rpc : pc + PC_STEP;
      else if (state == DRAIN && ack) pc <= redirect_in ? rpc : target;
      else if (state == BUF_FULL && redirect_in) pc <= rpc;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc_out <= '0;
      instr_out <= NOP_INSTR;
      valid_out <= 1'b0;
    end else if (redirect_in) begin
      instr_out <= NOP_INSTR;
      valid_out <= 1'b0;
    end else if (!stall_in) begin
      valid_out <= buf_full || fetch_hit;
      instr_out <= buf_full ? buf_instr : fetch_hit ? imem.imem_rdata : NOP_INSTR;
      pc_out <= buf_full ? buf_pc : fetch_hit ? pc : pc_out;
    end
endmodule
